// File: rtl/sort_unit_arbiter.sv
// sort_unit_arbiter
// Shares one pipelined four-element sort unit between two val/rdy requesters.
// Each issued job is tagged with its source port. The tag travels down a shift
// register that matches the sort unit latency. Results are steered into
// per-port response FIFOs. The sort unit cannot be stalled, so per-port credits
// reserve FIFO space for every job before it is issued.
// Build option: define SORT_ARB_FIXED_PRI_EN for fixed priority, where port 0
// wins whenever it is eligible. The default build uses round-robin arbitration.
module sort_unit_arbiter #(
    parameter int p_nbits     = 8,
    parameter int p_sort_lat  = 3,
    parameter int p_rsp_depth = 4
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               req0_val,
    output logic               req0_rdy,
    input  logic [p_nbits-1:0] req0_elm0,
    input  logic [p_nbits-1:0] req0_elm1,
    input  logic [p_nbits-1:0] req0_elm2,
    input  logic [p_nbits-1:0] req0_elm3,

    input  logic               req1_val,
    output logic               req1_rdy,
    input  logic [p_nbits-1:0] req1_elm0,
    input  logic [p_nbits-1:0] req1_elm1,
    input  logic [p_nbits-1:0] req1_elm2,
    input  logic [p_nbits-1:0] req1_elm3,

    output logic               resp0_val,
    input  logic               resp0_rdy,
    output logic [p_nbits-1:0] resp0_elm0,
    output logic [p_nbits-1:0] resp0_elm1,
    output logic [p_nbits-1:0] resp0_elm2,
    output logic [p_nbits-1:0] resp0_elm3,

    output logic               resp1_val,
    input  logic               resp1_rdy,
    output logic [p_nbits-1:0] resp1_elm0,
    output logic [p_nbits-1:0] resp1_elm1,
    output logic [p_nbits-1:0] resp1_elm2,
    output logic [p_nbits-1:0] resp1_elm3,

    output logic               sort_in_val,
    output logic [p_nbits-1:0] sort_in0,
    output logic [p_nbits-1:0] sort_in1,
    output logic [p_nbits-1:0] sort_in2,
    output logic [p_nbits-1:0] sort_in3,

    input  logic               sort_out_val,
    input  logic [p_nbits-1:0] sort_out0,
    input  logic [p_nbits-1:0] sort_out1,
    input  logic [p_nbits-1:0] sort_out2,
    input  logic [p_nbits-1:0] sort_out3,

    output logic               idle
);

    localparam int c_aw = $clog2(p_rsp_depth);      // FIFO address width
    localparam int c_cw = $clog2(p_rsp_depth + 1);  // credit counter width
    localparam int c_ww = 4 * p_nbits;              // packed four-element word
    localparam logic [c_cw-1:0] c_cred_init = c_cw'(p_rsp_depth);

    // Per-port vectors: bit 0 is port 0 and bit 1 is port 1.
    logic [1:0]            req_val;
    logic [1:0]            req_rdy;
    logic [1:0]            resp_val;
    logic [1:0]            resp_rdy;
    logic [1:0]            elig;
    logic [1:0]            grant;
    logic [1:0]            fire;
    logic [1:0]            pop;
    logic [1:0]            empty;
    logic [1:0]            cred_nz;
    logic                  issue;
    logic [1:0][c_ww-1:0]  req_word;
    logic [1:0][c_ww-1:0]  resp_word;
    logic [c_ww-1:0]       sort_in_word;
    logic [c_ww-1:0]       sort_out_word;

    // Tag pipeline: one {valid, port} pair per sort-unit stage.
    logic [p_sort_lat-1:0] tag_vld_q;
    logic [p_sort_lat-1:0] tag_vld_d;
    logic [p_sort_lat-1:0] tag_port_q;
    logic [p_sort_lat-1:0] tag_port_d;
    logic                  wb_vld;
    logic                  wb_port;

    // Port bundling. Element 0 sits in the least-significant slice.
    assign req_val     = {req1_val, req0_val};
    assign resp_rdy    = {resp1_rdy, resp0_rdy};
    assign req_word[0] = {req0_elm3, req0_elm2, req0_elm1, req0_elm0};
    assign req_word[1] = {req1_elm3, req1_elm2, req1_elm1, req1_elm0};
    assign sort_out_word = {sort_out3, sort_out2, sort_out1, sort_out0};

    assign req0_rdy  = req_rdy[0];
    assign req1_rdy  = req_rdy[1];
    assign resp0_val = resp_val[0];
    assign resp1_val = resp_val[1];
    assign {resp0_elm3, resp0_elm2, resp0_elm1, resp0_elm0} = resp_word[0];
    assign {resp1_elm3, resp1_elm2, resp1_elm1, resp1_elm0} = resp_word[1];
    assign {sort_in3, sort_in2, sort_in1, sort_in0} = sort_in_word;
    assign sort_in_val = issue;

    // A port may issue only while it holds a credit. During reset nothing is
    // eligible, so the ready signals stay low.
    assign elig = req_val & cred_nz & {2{reset_n}};

`ifdef SORT_ARB_FIXED_PRI_EN
    // Fixed priority: port 0 wins whenever it is eligible.
    always_comb begin
        grant = 2'b00;
        if (elig[0]) begin
            grant = 2'b01;
        end else if (elig[1]) begin
            grant = 2'b10;
        end
    end
`else
    // last_q holds the port that issued most recently. It resets to 1 so that
    // port 0 wins the first contended cycle.
    logic last_q;
    logic last_d;

    // Round-robin: when both ports are eligible, grant the port that was not
    // granted last. A single eligible port is always granted.
    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    // Update the pointer to the issuing port on every issue.
    always_comb begin
        last_d = last_q;
        if (issue) begin
            last_d = fire[1];
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign req_rdy = elig & grant;
    assign fire    = req_val & req_rdy;
    assign issue   = |fire;

    // Drive the winner's elements to the sort unit in the same cycle. Drive
    // zeros when nothing issues.
    always_comb begin
        sort_in_word = '0;
        if (fire[0]) begin
            sort_in_word = req_word[0];
        end else if (fire[1]) begin
            sort_in_word = req_word[1];
        end
    end

    // Shift the tags one stage per cycle. Stage 0 takes the job issued this cycle.
    always_comb begin
        tag_vld_d     = tag_vld_q << 1;
        tag_port_d    = tag_port_q << 1;
        tag_vld_d[0]  = issue;
        tag_port_d[0] = fire[1];
    end

    // Tag pipeline registers. Reset discards every job in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_vld_q  <= '0;
            tag_port_q <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
        end
    end

    // The final tag stage is aligned with sort_out_val. A result arriving
    // without a valid tag is dropped.
    assign wb_vld  = tag_vld_q[p_sort_lat-1];
    assign wb_port = tag_port_q[p_sort_lat-1];

    assign idle = ~reset_n | ((tag_vld_q == '0) & (&empty));

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        localparam logic c_port = 1'(gi);

        // Pointers carry one extra wrap bit. Equal pointers mean empty.
        // Pointers that differ only in the MSB mean full.
        logic [c_aw:0]   wr_ptr_q;
        logic [c_aw:0]   wr_ptr_d;
        logic [c_aw:0]   rd_ptr_q;
        logic [c_aw:0]   rd_ptr_d;
        logic [c_cw-1:0] cred_q;
        logic [c_cw-1:0] cred_d;
        logic [c_ww-1:0] mem_q [p_rsp_depth];
        logic            push;
        logic            full;

        assign push      = wb_vld & (wb_port == c_port);
        assign empty[gi] = (wr_ptr_q == rd_ptr_q);
        assign full      = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                           (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);

        assign resp_val[gi]  = reset_n & ~empty[gi];
        assign pop[gi]       = resp_val[gi] & resp_rdy[gi];
        assign cred_nz[gi]   = (cred_q != '0);
        assign resp_word[gi] = mem_q[rd_ptr_q[c_aw-1:0]];

        // Next-state logic for the pointers and credits. A fire and a pop in
        // the same cycle leave the credit count unchanged.
        always_comb begin
            wr_ptr_d = wr_ptr_q + {{c_aw{1'b0}}, push};
            rd_ptr_d = rd_ptr_q + {{c_aw{1'b0}}, pop[gi]};
            cred_d   = cred_q - {{(c_cw-1){1'b0}}, fire[gi]}
                              + {{(c_cw-1){1'b0}}, pop[gi]};
        end

        // Pointer and credit registers. Reset empties the FIFO and restores
        // all credits.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cred_q   <= c_cred_init;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cred_q   <= cred_d;
            end
        end

        // FIFO storage write. Storage contents need no reset because the
        // pointers gate every read.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q[c_aw-1:0]] <= sort_out_word;
            end
        end

`ifndef SYNTHESIS
        // Credits should make overflow unreachable.
        a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
            !(push && full));
`endif
    end

`ifndef SYNTHESIS
    // The sort unit must return exactly one result per tagged job, on time.
    a_tag_align: assert property (@(posedge clk) disable iff (!reset_n)
        wb_vld == sort_out_val);
`endif

endmodule
